student_status_reader: RTL and testbench
========================================

Name: student_status_reader

Overview:
- SoC-side consumer of the four 32-bit status words driven by a student area: status_0..status_3.
- Treats each word as asynchronous: two-flop synchronises every bit, then accepts a word only after it has been stable for a programmable number of cycles, which removes multi-bit skew.
- Exposes the captured words, per-word change flags and an interrupt mask over an APB3 slave.
- Sits between the student area and the system APB interconnect.

Parameters:
- STABLE_CYCLES, 4: consecutive stable cycles required before a synchronised word is captured; legal range 1..255.
- APB_AW, 5: APB address width; register map uses byte offsets 0x00..0x1C.

Ports:
- clk_in  input  1  system clock
- reset_int  input  1  synchronous, active-high reset
- status_0_in  input  32  student status word 0, asynchronous
- status_1_in  input  32  student status word 1, asynchronous
- status_2_in  input  32  student status word 2, asynchronous
- status_3_in  input  32  student status word 3, asynchronous
- psel_in  input  1  APB select
- penable_in  input  1  APB enable
- pwrite_in  input  1  APB write
- paddr_in  input  APB_AW  APB byte address
- pwdata_in  input  32  APB write data
- prdata_out  output  32  APB read data
- pready_out  output  1  APB ready
- pslverr_out  output  1  APB error
- irq_out  output  1  level interrupt, OR of masked change flags

Behaviour:
- Reset: all synchroniser flops, candidates, counters, captured words, CHANGE, MASK, prdata_out, pslverr_out and irq_out are 0. pready_out is 0 in reset.
- Synchroniser: two flops per bit, 128 bits total; no reset-free flops.
- Per-word stability filter:
  - Holds a candidate register and a counter of width clog2(STABLE_CYCLES).
  - If synced != candidate: candidate <= synced, counter <= 0.
  - Else if counter < STABLE_CYCLES-1: counter increments.
  - Else if candidate != captured: captured <= candidate and CHANGE[i] set.
  - The counter saturates; it does not wrap.
- Latency: an input held constant updates its captured word on the (STABLE_CYCLES+3)th rising edge after the first edge that samples it (7 edges at the default).
- Any toggle inside the window restarts the count. A word that never settles is never captured.
- A word that returns to the captured value before the window completes produces no change event.
- Register map (byte offsets):
  - 0x00..0x0C STATUS0..3: RO captured words.
  - 0x10 CHANGE: bits[3:0] sticky, write-1-to-clear.
  - 0x14 MASK: bits[3:0], RW.
  - 0x18 RAW: RO, bits[3:0] = per-word "filter currently unsettled" (candidate != captured).
  - 0x1C TIMESTAMP: see Optional Feature. Reserved bits read 0.
- APB3 timing:
  - Zero wait states: pready_out is 1 whenever psel_in & penable_in, otherwise 0.
  - prdata_out and pslverr_out are valid in the access phase and are 0 outside it.
  - Write side effects commit on the access-phase edge.
- pslverr_out = 1 for:
  - an address above 0x1C;
  - an unaligned address (paddr_in[1:0] != 0);
  - a write to a RO register.
  Errored writes have no side effect.
- Simultaneous CHANGE W1C and a new capture on the same word in the same cycle: the set wins and the flag stays 1.
- irq_out = |(CHANGE & MASK), decoded from registered state only, with no combinational path from APB inputs. It deasserts the cycle after the clearing write or the mask write.
- Reset asserted mid-filter or mid-transfer returns everything to reset values on the next edge. After reset release, an input that is already nonzero is captured after the normal latency and sets CHANGE.

Optional Feature:
- Macro: STUDENT_STATUS_TIMESTAMP_EN.
- Defined:
  - Adds a 32-bit free-running cycle counter; it resets to 0 and wraps from 0xFFFFFFFF to 0.
  - Every capture event loads the counter value into TIMESTAMP (0x1C, RO).
  - If several words capture in the same cycle, a single timestamp is stored.
- Undefined: the counter is absent and 0x1C reads 0 with pslverr_out = 0.

Test Plan:
- Reset, then read 0x00..0x1C -> all 0; pslverr 0; irq_out 0; pready high only in access phase.
- Drive status_1_in = 0xA5A5_0001 steady, STABLE_CYCLES=4 -> STATUS1 = 0xA5A5_0001 at the 7th edge, not the 6th; CHANGE = 0x2; irq_out stays 0 until MASK = 0x2, then 1.
- Toggle status_2_in bit0 every 3 cycles for 50 cycles, then hold 0x3 -> no capture during toggling and RAW[2]=1; final STATUS2 = 0x3 with exactly one CHANGE[2] set.
- With CHANGE[0] set, write 0x1 to 0x10 on the same edge a new status_0 capture occurs -> CHANGE[0] remains 1. Clear again with no capture -> 0, and irq_out drops the next cycle.
- Write to 0x04; read 0x20; read 0x02 -> pslverr_out 1 on each, STATUS1 unchanged.
- With STUDENT_STATUS_TIMESTAMP_EN defined, capture status_3 change at cycle 100 after reset -> TIMESTAMP reads the counter value at that capture edge. With the macro undefined, 0x1C reads 0.

Source files
------------

// File: rtl/student_status_reader.sv
// SoC-side capture of four asynchronous student status words, filtered for stability and
// exposed over APB3. Optional capture timestamp enabled by STUDENT_STATUS_TIMESTAMP_EN.
module student_status_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned APB_AW        = 5
) (
    input  logic              clk_in,
    input  logic              reset_int,
    input  logic [31:0]       status_0_in,
    input  logic [31:0]       status_1_in,
    input  logic [31:0]       status_2_in,
    input  logic [31:0]       status_3_in,
    input  logic              psel_in,
    input  logic              penable_in,
    input  logic              pwrite_in,
    input  logic [APB_AW-1:0] paddr_in,
    input  logic [31:0]       pwdata_in,
    output logic [31:0]       prdata_out,
    output logic              pready_out,
    output logic              pslverr_out,
    output logic              irq_out
);

    localparam int unsigned      CntW     = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CntW-1:0]  CntMax   = CntW'(STABLE_CYCLES - 1);
    localparam logic [APB_AW-1:0] LastAddr = APB_AW'(32'h1C);

    logic [31:0]     status_in [4];
    logic [31:0]     sync1_q   [4];
    logic [31:0]     sync2_q   [4];
    logic [31:0]     cand_q    [4];
    logic [31:0]     capt_q    [4];
    logic [CntW-1:0] cnt_q     [4];
    logic [3:0]      capture;
    logic [3:0]      raw;
    logic [3:0]      change_q, change_d;
    logic [3:0]      mask_q;
    logic [31:0]     stamp;

    assign status_in[0] = status_0_in;
    assign status_in[1] = status_1_in;
    assign status_in[2] = status_2_in;
    assign status_in[3] = status_3_in;

    // A capture fires only once the candidate has held for the full window and is new.
    always_comb begin
        capture = '0;
        raw     = '0;
        for (int i = 0; i < 4; i++) begin
            capture[i] = (sync2_q[i] == cand_q[i]) && !(cnt_q[i] < CntMax) &&
                         (cand_q[i] != capt_q[i]);
            raw[i]     = (cand_q[i] != capt_q[i]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_int) begin
            for (int i = 0; i < 4; i++) begin
                sync1_q[i] <= '0;
                sync2_q[i] <= '0;
                cand_q[i]  <= '0;
                capt_q[i]  <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                sync1_q[i] <= status_in[i];
                sync2_q[i] <= sync1_q[i];
                if (sync2_q[i] != cand_q[i]) begin
                    cand_q[i] <= sync2_q[i];
                    cnt_q[i]  <= '0;
                end else if (cnt_q[i] < CntMax) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end else if (capture[i]) begin
                    capt_q[i] <= cand_q[i];
                end
            end
        end
    end

`ifdef STUDENT_STATUS_TIMESTAMP_EN
    logic [31:0] tick_q;
    logic [31:0] stamp_q;

    always_ff @(posedge clk_in) begin
        if (reset_int) begin
            tick_q  <= '0;
            stamp_q <= '0;
        end else begin
            tick_q <= tick_q + 32'd1;
            if (|capture) begin
                stamp_q <= tick_q;
            end
        end
    end

    assign stamp = stamp_q;
`else
    assign stamp = '0;
`endif

    // APB decode
    logic       access;
    logic       in_range;
    logic       aligned;
    logic [2:0] reg_idx;
    logic       writable;
    logic       err;
    logic       wr_ok;
    logic [31:0] rdata;
    logic       unused_pwdata;

    assign unused_pwdata = ^pwdata_in[31:4];

    assign access   = psel_in & penable_in;
    assign in_range = (paddr_in <= LastAddr);
    assign aligned  = (paddr_in[1:0] == 2'b00);
    assign reg_idx  = paddr_in[4:2];
    assign writable = (reg_idx == 3'd4) || (reg_idx == 3'd5);
    assign err      = !in_range || !aligned || (pwrite_in && !writable);
    assign wr_ok    = access && pwrite_in && !err;

    always_comb begin
        rdata = '0;
        unique case (reg_idx)
            3'd0:    rdata = capt_q[0];
            3'd1:    rdata = capt_q[1];
            3'd2:    rdata = capt_q[2];
            3'd3:    rdata = capt_q[3];
            3'd4:    rdata = {28'd0, change_q};
            3'd5:    rdata = {28'd0, mask_q};
            3'd6:    rdata = {28'd0, raw};
            3'd7:    rdata = stamp;
            default: rdata = '0;
        endcase
    end

    // A W1C on the same edge as a capture loses to the set.
    always_comb begin
        change_d = change_q;
        if (wr_ok && (reg_idx == 3'd4)) begin
            change_d = change_d & ~pwdata_in[3:0];
        end
        change_d = change_d | capture;
    end

    always_ff @(posedge clk_in) begin
        if (reset_int) begin
            change_q <= '0;
            mask_q   <= '0;
        end else begin
            change_q <= change_d;
            if (wr_ok && (reg_idx == 3'd5)) begin
                mask_q <= pwdata_in[3:0];
            end
        end
    end

    assign pready_out  = access && !reset_int;
    assign pslverr_out = access && err && !reset_int;
    assign prdata_out  = (access && !pwrite_in && !err && !reset_int) ? rdata : 32'd0;
    assign irq_out     = |(change_q & mask_q);

endmodule

// File: tb/tb_student_status_reader.sv
// Directed bench for student_status_reader: latency, filtering, W1C, errors and reset.
module tb_student_status_reader;

    logic        clk_in = 1'b0;
    logic        reset_int;
    logic [31:0] s0, s1, s2, s3;
    logic        psel, penable, pwrite;
    logic [5:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr, irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd;
    logic        err, rdy, rdy_setup, irq_acc;

    always #5 clk_in = ~clk_in;

    student_status_reader #(
        .STABLE_CYCLES(4),
        .APB_AW(6)
    ) dut (
        .clk_in(clk_in),
        .reset_int(reset_int),
        .status_0_in(s0),
        .status_1_in(s1),
        .status_2_in(s2),
        .status_3_in(s3),
        .psel_in(psel),
        .penable_in(penable),
        .pwrite_in(pwrite),
        .paddr_in(paddr),
        .pwdata_in(pwdata),
        .prdata_out(prdata),
        .pready_out(pready),
        .pslverr_out(pslverr),
        .irq_out(irq)
    );

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Called 1 time unit after a rising edge E; samples after E+1, commits at E+2.
    task automatic apb(input logic wr, input logic [5:0] addr, input logic [31:0] wd);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        #1 rdy_setup = pready;
        @(posedge clk_in);
        #1 penable = 1'b1;
        #1 rd = prdata; err = pslverr; rdy = pready; irq_acc = irq;
        @(posedge clk_in);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic test_reset();
        reset_int = 1'b1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = '0; pwdata = '0;
        s0 = '0; s1 = '0; s2 = '0; s3 = '0;
        cycles(3);
        checks++;
        if (pready !== 1'b0) begin
            failures++; $display("FAIL reset_pready got=%b want=0", pready);
        end
        checks++;
        if (prdata !== 32'd0 || pslverr !== 1'b0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_outs got prdata=%h err=%b irq=%b want 0/0/0", prdata, pslverr, irq);
        end
        psel = 1'b0; penable = 1'b0;
        reset_int = 1'b0;
        for (int a = 0; a < 8; a++) begin
            apb(1'b0, 6'(a * 4), 32'd0);
            checks++;
            if (rd !== 32'd0 || err !== 1'b0) begin
                failures++; $display("FAIL reset_read a=%0h got=%h err=%b want=0 err=0", a * 4, rd, err);
            end
            checks++;
            if (rdy !== 1'b1 || rdy_setup !== 1'b0) begin
                failures++;
                $display("FAIL reset_pready_phase a=%0h got acc=%b setup=%b want 1/0", a * 4, rdy, rdy_setup);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL reset_irq got=%b want=0", irq);
        end
    endtask

    task automatic test_latency();
        s1 = 32'hA5A5_0001;
        cycles(5);
        apb(1'b0, 6'h04, 32'd0);
        checks++;
        if (rd !== 32'd0) begin
            failures++; $display("FAIL lat_edge6 got=%h want=00000000", rd);
        end
        apb(1'b0, 6'h04, 32'd0);
        checks++;
        if (rd !== 32'hA5A5_0001) begin
            failures++; $display("FAIL lat_captured got=%h want=a5a50001", rd);
        end
        apb(1'b0, 6'h10, 32'd0);
        checks++;
        if (rd !== 32'h2) begin
            failures++; $display("FAIL lat_change got=%h want=2", rd);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL lat_irq_unmasked got=%b want=0", irq);
        end
        apb(1'b1, 6'h14, 32'h2);
        checks++;
        if (irq !== 1'b1 || err !== 1'b0) begin
            failures++; $display("FAIL lat_irq_masked got irq=%b err=%b want 1/0", irq, err);
        end
        s1 = 32'h1234_5678;
        cycles(6);
        apb(1'b0, 6'h04, 32'd0);
        checks++;
        if (rd !== 32'h1234_5678) begin
            failures++; $display("FAIL lat_edge7 got=%h want=12345678", rd);
        end
    endtask

    task automatic test_filter();
        s2 = 32'h2;
        fork
            begin
                for (int t = 0; t < 17; t++) begin
                    cycles(3);
                    s2[0] = ~s2[0];
                end
            end
            begin
                cycles(20);
                apb(1'b0, 6'h18, 32'd0);
                checks++;
                if (rd !== 32'h4) begin
                    failures++; $display("FAIL filt_raw_toggling got=%h want=4", rd);
                end
                apb(1'b0, 6'h08, 32'd0);
                checks++;
                if (rd !== 32'd0) begin
                    failures++; $display("FAIL filt_no_capture got=%h want=0", rd);
                end
                apb(1'b0, 6'h10, 32'd0);
                checks++;
                if (rd !== 32'h2) begin
                    failures++; $display("FAIL filt_change_toggling got=%h want=2", rd);
                end
            end
        join
        cycles(10);
        apb(1'b0, 6'h08, 32'd0);
        checks++;
        if (rd !== 32'h3) begin
            failures++; $display("FAIL filt_final got=%h want=3", rd);
        end
        apb(1'b0, 6'h10, 32'd0);
        checks++;
        if (rd !== 32'h6) begin
            failures++; $display("FAIL filt_change got=%h want=6", rd);
        end
        apb(1'b0, 6'h18, 32'd0);
        checks++;
        if (rd !== 32'd0) begin
            failures++; $display("FAIL filt_raw_settled got=%h want=0", rd);
        end
        apb(1'b1, 6'h10, 32'h4);
        cycles(10);
        apb(1'b0, 6'h10, 32'd0);
        checks++;
        if (rd !== 32'h2) begin
            failures++; $display("FAIL filt_single_event got=%h want=2", rd);
        end
    endtask

    task automatic test_w1c_collision();
        apb(1'b1, 6'h10, 32'hF);
        apb(1'b1, 6'h14, 32'h1);
        s0 = 32'h11;
        cycles(10);
        apb(1'b0, 6'h10, 32'd0);
        checks++;
        if (rd !== 32'h1 || irq !== 1'b1) begin
            failures++; $display("FAIL w1c_setup got change=%h irq=%b want 1/1", rd, irq);
        end
        s0 = 32'h22;
        cycles(5);
        apb(1'b1, 6'h10, 32'h1);
        apb(1'b0, 6'h10, 32'd0);
        checks++;
        if (rd !== 32'h1) begin
            failures++; $display("FAIL w1c_set_wins got=%h want=1", rd);
        end
        apb(1'b0, 6'h00, 32'd0);
        checks++;
        if (rd !== 32'h22) begin
            failures++; $display("FAIL w1c_status0 got=%h want=22", rd);
        end
        apb(1'b1, 6'h10, 32'h1);
        checks++;
        if (irq_acc !== 1'b1 || irq !== 1'b0) begin
            failures++; $display("FAIL w1c_irq_drop got acc=%b after=%b want 1/0", irq_acc, irq);
        end
        apb(1'b0, 6'h10, 32'd0);
        checks++;
        if (rd !== 32'd0) begin
            failures++; $display("FAIL w1c_cleared got=%h want=0", rd);
        end
    endtask

    task automatic test_errors();
        apb(1'b1, 6'h04, 32'hDEAD_BEEF);
        checks++;
        if (err !== 1'b1 || rdy !== 1'b1) begin
            failures++; $display("FAIL err_wr_ro got err=%b rdy=%b want 1/1", err, rdy);
        end
        apb(1'b0, 6'h20, 32'd0);
        checks++;
        if (err !== 1'b1) begin
            failures++; $display("FAIL err_range got=%b want=1", err);
        end
        apb(1'b0, 6'h02, 32'd0);
        checks++;
        if (err !== 1'b1) begin
            failures++; $display("FAIL err_unaligned got=%b want=1", err);
        end
        apb(1'b0, 6'h04, 32'd0);
        checks++;
        if (rd !== 32'h1234_5678 || err !== 1'b0) begin
            failures++; $display("FAIL err_status1_kept got=%h err=%b want=12345678 0", rd, err);
        end
        apb(1'b1, 6'h15, 32'hF);
        apb(1'b0, 6'h14, 32'd0);
        checks++;
        if (rd !== 32'h1) begin
            failures++; $display("FAIL err_no_side_effect mask got=%h want=1", rd);
        end
    endtask

    task automatic test_reset_mid();
        s3 = 32'h77;
        cycles(3);
        reset_int = 1'b1;
        cycles(1);
        reset_int = 1'b0;
        cycles(5);
        apb(1'b0, 6'h0C, 32'd0);
        checks++;
        if (rd !== 32'd0) begin
            failures++; $display("FAIL rst_mid_early got=%h want=0", rd);
        end
        apb(1'b0, 6'h0C, 32'd0);
        checks++;
        if (rd !== 32'h77) begin
            failures++; $display("FAIL rst_mid_capture got=%h want=77", rd);
        end
        apb(1'b0, 6'h10, 32'd0);
        checks++;
        if (rd !== 32'hF) begin
            failures++; $display("FAIL rst_mid_change got=%h want=f", rd);
        end
        apb(1'b0, 6'h14, 32'd0);
        checks++;
        if (rd !== 32'd0 || irq !== 1'b0) begin
            failures++; $display("FAIL rst_mid_mask got=%h irq=%b want 0/0", rd, irq);
        end
    endtask

    task automatic test_timestamp();
`ifdef STUDENT_STATUS_TIMESTAMP_EN
        s0 = '0; s1 = '0; s2 = '0; s3 = '0;
        reset_int = 1'b1;
        cycles(2);
        reset_int = 1'b0;
        cycles(93);
        s3 = 32'h5;
        cycles(10);
        apb(1'b0, 6'h1C, 32'd0);
        checks++;
        if (rd !== 32'd99 || err !== 1'b0) begin
            failures++; $display("FAIL ts_value got=%0d err=%b want=99 0", rd, err);
        end
`else
        apb(1'b0, 6'h1C, 32'd0);
        checks++;
        if (rd !== 32'd0 || err !== 1'b0) begin
            failures++; $display("FAIL ts_absent got=%h err=%b want=0 0", rd, err);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_latency();
        test_filter();
        test_w1c_collision();
        test_errors();
        test_reset_mid();
        test_timestamp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
